// File: rtl/multdiv_iter_param_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_state_t : control FSM states (IDLE, MUL, DIV, DONE)
//   md_op_t    : operation latched at the start edge
package md_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_t;

endpackage

// File: rtl/multdiv_iter_param_if.sv
// Operand/control/result bundle of the multiply/divide unit.
//   master : drives operands, start pulses, signed mode and flush
//   slave  : returns low/high result, exception, ready pulse and running
interface multdiv_iter_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             ctrl_signed;
    logic             ctrl_flush;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_result_hi;
    logic             data_exception;
    logic             data_resultRDY;
    logic             running;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_signed, ctrl_flush,
        input  data_result, data_result_hi, data_exception, data_resultRDY, running
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_signed, ctrl_flush,
        output data_result, data_result_hi, data_exception, data_resultRDY, running
    );
endinterface

// File: rtl/multdiv_iter_param_core.sv
// Unsigned iteration datapath: one shift-add (multiply) or one restoring
// subtract-and-shift (divide) step per enabled cycle on operand magnitudes.
//   clock, reset : clock and synchronous active-high reset
//   load_i       : load a_i into the shift register, b_i as multiplicand/divisor
//   en_i         : perform one step
//   div_i        : 1 = divide step, 0 = multiply step
//   acc_nx_o     : accumulator after this step (product high half / remainder)
//   sh_nx_o      : shift register after this step (product low half / quotient)
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_nx_o,
    output logic [WIDTH-1:0] sh_nx_o
);
    logic [WIDTH-1:0] acc_q, sh_q, opb_q;
    logic [WIDTH:0]   mul_sum, trial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the {acc, sh} pair right; the carry moves into acc.
        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        // Divide: bring the next dividend bit into the partial remainder.
        // The remainder is always below the divisor, so the difference of a
        // successful trial fits in WIDTH bits.
        trial   = {acc_q, sh_q[WIDTH-1]};
        ge      = trial >= {1'b0, opb_q};
        diff    = trial[WIDTH-1:0] - opb_q;
        if (div_i) begin
            acc_nx_o = ge ? diff : trial[WIDTH-1:0];
            sh_nx_o  = {sh_q[WIDTH-2:0], ge};
        end else begin
            acc_nx_o = mul_sum[WIDTH:1];
            sh_nx_o  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            sh_q  <= '0;
            opb_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            sh_q  <= a_i;
            opb_q <= b_i;
        end else if (en_i) begin
            acc_q <= acc_nx_o;
            sh_q  <= sh_nx_o;
        end
    end
endmodule

// File: rtl/multdiv_iter_param.sv
// Iterative signed/unsigned multiply/divide unit, one bit per cycle.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : operands, start pulses, signed mode, flush in;
//                  low result/quotient, high result/remainder, exception,
//                  one-cycle ready pulse and running (stall) out
// The FSM, iteration counter, sign handling and exception logic live here;
// the magnitude arithmetic lives in md_iter_core.
module multdiv_iter_param
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic                 clock,
    input logic                 reset,
    multdiv_iter_param_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    md_op_t             op_q;
    logic               sgn_q, a_neg_q, b_neg_q, b_zero_q, ovf_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   res_q, hi_q, res_d, hi_d;
    logic               exc_q, exc_d;
    logic               start, finish, busy;
    logic               a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_mag, b_mag, acc_nx, sh_nx;
    logic [2*WIDTH-1:0] prod;

    assign busy = (state_q == MUL) || (state_q == DIV);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Starts are only seen in IDLE/DONE; a flush in the same cycle squashes them.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if ((bus.ctrl_MULT || bus.ctrl_DIV) && !bus.ctrl_flush) begin
                    start   = 1'b1;
                    state_d = bus.ctrl_MULT ? MUL : DIV;
                end
            end
            MUL, DIV: begin
                if (bus.ctrl_flush) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Magnitudes go to the core; MIN maps onto 2^(WIDTH-1), which is the
    // correct unsigned magnitude.
    assign a_neg_in = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
    assign b_neg_in = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
    assign a_mag    = a_neg_in ? -bus.data_operandA : bus.data_operandA;
    assign b_mag    = b_neg_in ? -bus.data_operandB : bus.data_operandB;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset    (reset),
        .load_i   (start),
        .en_i     (busy && !bus.ctrl_flush),
        .div_i    (state_q == DIV),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .acc_nx_o (acc_nx),
        .sh_nx_o  (sh_nx)
    );

    // Sign fix-up and exceptions, taken from the core's final step values so
    // the result is registered on the same edge that enters DONE.
    always_comb begin
        res_d = '0;
        hi_d  = '0;
        exc_d = 1'b0;
        prod  = (a_neg_q ^ b_neg_q) ? -{acc_nx, sh_nx} : {acc_nx, sh_nx};
        if (op_q == OP_MULT) begin
            res_d = prod[WIDTH-1:0];
            hi_d  = prod[2*WIDTH-1:WIDTH];
            exc_d = sgn_q ? (hi_d != {WIDTH{res_d[WIDTH-1]}}) : (hi_d != '0);
        end else if (b_zero_q) begin
            hi_d  = a_q;
            exc_d = 1'b1;
        end else if (ovf_q) begin
            res_d = MIN_VAL;
            exc_d = 1'b1;
        end else begin
            res_d = (a_neg_q ^ b_neg_q) ? -sh_nx : sh_nx;
            hi_d  = a_neg_q ? -acc_nx : acc_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            sgn_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            exc_q    <= 1'b0;
        end else if (start) begin
            cnt_q    <= '0;
            op_q     <= bus.ctrl_MULT ? OP_MULT : OP_DIV;
            sgn_q    <= bus.ctrl_signed;
            a_neg_q  <= a_neg_in;
            b_neg_q  <= b_neg_in;
            b_zero_q <= (bus.data_operandB == '0);
            ovf_q    <= bus.ctrl_signed && (bus.data_operandA == MIN_VAL) &&
                        (bus.data_operandB == '1);
            a_q      <= bus.data_operandA;
            res_q    <= '0;
            hi_q     <= '0;
            exc_q    <= 1'b0;
        end else if (busy) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (finish) begin
                res_q <= res_d;
                hi_q  <= hi_d;
                exc_q <= exc_d;
            end
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_result_hi = hi_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == DONE);
    assign bus.running        = busy;
endmodule
